// File: rtl/gate_truth_checker_pkg.sv
// Shared definitions for the gate truth checker: gate_sel codes,
// FSM state encoding and the index of the last input vector.
package gate_truth_checker_pkg;

  localparam logic [2:0] GSEL_AND  = 3'b000;
  localparam logic [2:0] GSEL_OR   = 3'b001;
  localparam logic [2:0] GSEL_XOR  = 3'b010;
  localparam logic [2:0] GSEL_NAND = 3'b011;
  localparam logic [2:0] GSEL_NOR  = 3'b100;
  localparam logic [2:0] GSEL_XNOR = 3'b101;
  localparam logic [2:0] GSEL_NOTA = 3'b110;
  localparam logic [2:0] GSEL_BUFA = 3'b111;

  // Vectors are walked 00, 01, 10, 11; this is the final one
  localparam logic [1:0] VEC_LAST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/gate_truth_checker_ref_model.sv
// Combinational reference gate: returns the value x that the selected
// 2-input function should produce for inputs a and b.
module gate_ref_model
  import gate_truth_checker_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       x
);

  // Decode the selected function into the expected gate output
  always_comb begin
    x = 1'b0;
    case (sel)
      GSEL_AND:  x = a & b;
      GSEL_OR:   x = a | b;
      GSEL_XOR:  x = a ^ b;
      GSEL_NAND: x = ~(a & b);
      GSEL_NOR:  x = ~(a | b);
      GSEL_XNOR: x = ~(a ^ b);
      GSEL_NOTA: x = ~a;
      GSEL_BUFA: x = a;
      default:   x = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Stimulus/check controller for a 2-input gate under test. Walks the four
// input vectors, lets each settle for SETTLE_CYCLES clocks, samples dut_x
// against the latched truth table and reports err_cnt / pass.
// Optional feature macro: GATE_CHECK_FAILLOG_EN adds first_fail_vec and
// first_fail_vld, which record the first mismatching vector of a run.
module gate_truth_checker
  import gate_truth_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       dut_x,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt
`ifdef GATE_CHECK_FAILLOG_EN
  ,
  output logic [1:0] first_fail_vec,
  output logic       first_fail_vld
`endif
);

  localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [1:0]       vec;
  logic [CNT_W-1:0] settle_cnt;
  logic [2:0]       sel_q;
  logic             expected_x;
  logic             mismatch;
  logic             accept;

  gate_ref_model u_ref (
    .sel (sel_q),
    .a   (vec[1]),
    .b   (vec[0]),
    .x   (expected_x)
  );

  assign mismatch = (dut_x != expected_x);
  assign accept   = (state == ST_IDLE) && start;

  // State register; reset aborts any run in progress
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state decode: settle each vector, sample once, finish after vector 3
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == CNT_LAST) next_state = ST_SAMPLE;
      ST_SAMPLE: next_state = (vec == VEC_LAST) ? ST_FINISH : ST_SETTLE;
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs; gate inputs are only driven while a run walks vectors
  always_comb begin
    busy  = (state != ST_IDLE);
    done  = (state == ST_FINISH);
    dut_a = 1'b0;
    dut_b = 1'b0;
    if (state == ST_SETTLE || state == ST_SAMPLE) begin
      dut_a = vec[1];
      dut_b = vec[0];
    end
  end

  // Run datapath: vector index, settle timer, latched select and results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec        <= 2'd0;
      settle_cnt <= '0;
      sel_q      <= 3'd0;
      err_cnt    <= 3'd0;
      pass       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_q      <= gate_sel;
            vec        <= 2'd0;
            settle_cnt <= '0;
            err_cnt    <= 3'd0;
            pass       <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == CNT_LAST) settle_cnt <= '0;
          else                        settle_cnt <= settle_cnt + 1'b1;
        end
        ST_SAMPLE: begin
          if (mismatch) err_cnt <= err_cnt + 3'd1;
          if (vec != VEC_LAST) vec <= vec + 2'd1;
        end
        ST_FINISH: begin
          pass <= (err_cnt == 3'd0);
          vec  <= 2'd0;
        end
        default: begin
          vec <= 2'd0;
        end
      endcase
    end
  end

`ifdef GATE_CHECK_FAILLOG_EN
  // Remember only the first mismatching vector of each run
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      first_fail_vec <= 2'd0;
      first_fail_vld <= 1'b0;
    end else if (state == ST_SAMPLE && mismatch && !first_fail_vld) begin
      first_fail_vec <= vec;
      first_fail_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Self-checking bench for gate_truth_checker. Two checker instances: one with
// the default settle time, one with SETTLE_CYCLES=2. Each drives a behavioural
// gate described by a 4-entry truth table, optionally delayed by 3 clocks.
// Honours GATE_CHECK_FAILLOG_EN when defined.
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_s [2];
  logic [2:0] sel_s   [2];
  logic       x_s     [2];
  logic       a_s     [2];
  logic       b_s     [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [2:0] err_s   [2];
`ifdef GATE_CHECK_FAILLOG_EN
  logic [1:0] ffv_s   [2];
  logic       ffl_s   [2];
`endif

  logic [3:0] dut_tbl [2];
  logic       dly_s   [2];
  logic [2:0] pipe_s  [2];

  int checks = 0;
  int errors = 0;

  int         done_cnt;
  int         done_at;
  logic       busy_first;
  logic       busy_after;
  logic [7:0] seq;
  int         seq_cnt;

  always #5 clk = ~clk;

  gate_truth_checker u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .gate_sel(sel_s[0]),
    .dut_x(x_s[0]), .dut_a(a_s[0]), .dut_b(b_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .pass(pass_s[0]), .err_cnt(err_s[0])
`ifdef GATE_CHECK_FAILLOG_EN
    , .first_fail_vec(ffv_s[0]), .first_fail_vld(ffl_s[0])
`endif
  );

  gate_truth_checker #(.SETTLE_CYCLES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .gate_sel(sel_s[1]),
    .dut_x(x_s[1]), .dut_a(a_s[1]), .dut_b(b_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .pass(pass_s[1]), .err_cnt(err_s[1])
`ifdef GATE_CHECK_FAILLOG_EN
    , .first_fail_vec(ffv_s[1]), .first_fail_vld(ffl_s[1])
`endif
  );

  // Behavioural gates under test: table lookup, optionally through a 3-clock delay
  always_comb begin
    x_s[0] = dly_s[0] ? pipe_s[0][2] : dut_tbl[0][{a_s[0], b_s[0]}];
    x_s[1] = dly_s[1] ? pipe_s[1][2] : dut_tbl[1][{a_s[1], b_s[1]}];
  end

  // Delay line for the slow gate model
  always @(posedge clk) begin
    pipe_s[0] <= {pipe_s[0][1:0], dut_tbl[0][{a_s[0], b_s[0]}]};
    pipe_s[1] <= {pipe_s[1][1:0], dut_tbl[1][{a_s[1], b_s[1]}]};
  end

  // Truth table of each function, bit i = output for input vector {a,b}=i
  function automatic logic [3:0] refTable(input logic [2:0] sel);
    case (sel)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b0110;
      3'd3:    return 4'b0111;
      3'd4:    return 4'b0001;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b0011;
      default: return 4'b1100;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Start a run on instance idx and watch it for a fixed number of cycles
  task automatic applyStimulus(input int idx, input logic [2:0] sel, input int settle,
                               input int inject_k, input logic [2:0] inject_sel, input int reset_k);
    int         span;
    logic [1:0] ab;
    logic [1:0] last_ab;
    span       = 4 * (settle + 1);
    done_cnt   = 0;
    done_at    = -1;
    busy_first = 1'b0;
    busy_after = 1'b1;
    seq        = 8'd0;
    seq_cnt    = 0;
    last_ab    = 2'd0;
    @(negedge clk);
    start_s[idx] = 1'b1;
    sel_s[idx]   = sel;
    @(negedge clk);
    start_s[idx] = 1'b0;
    for (int k = 0; k <= span + 3; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) busy_first = busy_s[idx];
      if (k == span + 1) busy_after = busy_s[idx];
      if (done_s[idx] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      ab = {a_s[idx], b_s[idx]};
      if (k < span && (seq_cnt == 0 || ab != last_ab)) begin
        seq     = {seq[5:0], ab};
        seq_cnt++;
        last_ab = ab;
      end
      if (inject_k >= 0 && k == inject_k) begin
        start_s[idx] = 1'b1;
        sel_s[idx]   = inject_sel;
      end
      if (inject_k >= 0 && k == inject_k + 1) start_s[idx] = 1'b0;
      if (reset_k >= 0 && k == reset_k) rst_n = 1'b0;
      if (reset_k >= 0 && k == reset_k + 1) begin
        rst_n = 1'b1;
        break;
      end
    end
  endtask

  // Compare a completed run against the truth-table model
  task automatic checkRun(input string tag, input int idx, input logic [2:0] sel,
                          input logic [3:0] tbl, input int settle);
    logic [3:0] want;
    int         exp_err;
    int         first;
    want    = refTable(sel);
    exp_err = 0;
    first   = -1;
    for (int i = 0; i < 4; i++) begin
      if (want[i] != tbl[i]) begin
        exp_err++;
        if (first < 0) first = i;
      end
    end
    checkOutput({tag, "_done_at"}, 16'(done_at), 16'(4 * (settle + 1)));
    checkOutput({tag, "_done_cnt"}, 16'(done_cnt), 16'd1);
    checkOutput({tag, "_busy_first"}, 16'(busy_first), 16'd1);
    checkOutput({tag, "_busy_after"}, 16'(busy_after), 16'd0);
    checkOutput({tag, "_vec_seq"}, {8'd0, seq}, 16'h001B);
    checkOutput({tag, "_vec_cnt"}, 16'(seq_cnt), 16'd4);
    checkOutput({tag, "_err_cnt"}, 16'(err_s[idx]), 16'(exp_err));
    checkOutput({tag, "_pass"}, 16'(pass_s[idx]), 16'(exp_err == 0));
`ifdef GATE_CHECK_FAILLOG_EN
    checkOutput({tag, "_ff_vld"}, 16'(ffl_s[idx]), 16'(first >= 0));
    checkOutput({tag, "_ff_vec"}, 16'(ffv_s[idx]), 16'((first >= 0) ? first : 0));
`endif
  endtask

  // Global time limit so a stuck run still ends the simulation
  initial begin
    #2000000;
    $display("[TB] FAIL timeout simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [2:0] rsel;
    logic [3:0] rtbl;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      sel_s[i]   = 3'd0;
      dut_tbl[i] = 4'b1110;
      dly_s[i]   = 1'b0;
      pipe_s[i]  = 3'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_a", 16'(a_s[0]), 16'd0);
    checkOutput("rst_b", 16'(b_s[0]), 16'd0);
    checkOutput("rst_busy", 16'(busy_s[0]), 16'd0);
    checkOutput("rst_done", 16'(done_s[0]), 16'd0);
    checkOutput("rst_pass", 16'(pass_s[0]), 16'd0);
    checkOutput("rst_err", 16'(err_s[0]), 16'd0);
    rst_n = 1'b1;

    $display("[TB] ideal OR gate, OR selected");
    dut_tbl[0] = 4'b1110;
    applyStimulus(0, 3'b001, 4, -1, 3'd0, -1);
    checkRun("or_ideal", 0, 3'b001, 4'b1110, 4);

    $display("[TB] stuck-at-0 gate, OR selected");
    dut_tbl[0] = 4'b0000;
    applyStimulus(0, 3'b001, 4, -1, 3'd0, -1);
    checkRun("stuck0", 0, 3'b001, 4'b0000, 4);

    $display("[TB] OR gate checked as AND");
    dut_tbl[0] = 4'b1110;
    applyStimulus(0, 3'b000, 4, -1, 3'd0, -1);
    checkRun("or_as_and", 0, 3'b000, 4'b1110, 4);

    $display("[TB] slow OR gate, 4 settle cycles");
    dly_s[0] = 1'b1;
    applyStimulus(0, 3'b001, 4, -1, 3'd0, -1);
    checkRun("slow_s4", 0, 3'b001, 4'b1110, 4);
    dly_s[0] = 1'b0;

    $display("[TB] slow OR gate, 2 settle cycles");
    dly_s[1] = 1'b1;
    applyStimulus(1, 3'b001, 2, -1, 3'd0, -1);
    checkOutput("slow_s2_done_at", 16'(done_at), 16'd12);
    checkOutput("slow_s2_pass", 16'(pass_s[1]), 16'd0);
    checkOutput("slow_s2_err_nonzero", 16'(err_s[1] != 3'd0), 16'd1);

    $display("[TB] restart and select change mid-run");
    applyStimulus(0, 3'b001, 4, 6, 3'b000, -1);
    checkRun("restart_ign", 0, 3'b001, 4'b1110, 4);

    $display("[TB] reset during sample of vector 10");
    dut_tbl[0] = 4'b0000;
    applyStimulus(0, 3'b001, 4, -1, 3'd0, 14);
    checkOutput("midrst_a", 16'(a_s[0]), 16'd0);
    checkOutput("midrst_b", 16'(b_s[0]), 16'd0);
    checkOutput("midrst_busy", 16'(busy_s[0]), 16'd0);
    checkOutput("midrst_done", 16'(done_s[0]), 16'd0);
    checkOutput("midrst_pass", 16'(pass_s[0]), 16'd0);
    checkOutput("midrst_err", 16'(err_s[0]), 16'd0);
`ifdef GATE_CHECK_FAILLOG_EN
    checkOutput("midrst_ff_vld", 16'(ffl_s[0]), 16'd0);
`endif
    dut_tbl[0] = 4'b1110;
    applyStimulus(0, 3'b001, 4, -1, 3'd0, -1);
    checkRun("after_rst", 0, 3'b001, 4'b1110, 4);

    $display("[TB] randomized gate tables");
    for (int n = 0; n < 8; n++) begin
      rsel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) rtbl = refTable(rsel);
      else                           rtbl = 4'($urandom_range(0, 15));
      dut_tbl[0] = rtbl;
      applyStimulus(0, rsel, 4, -1, 3'd0, -1);
      checkRun($sformatf("rand%0d", n), 0, rsel, rtbl, 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
